// File: rtl/instruction_memory_loadable.sv
// Run-time loadable instruction memory: valid/ready load port, registered fetch port.
// Optional load checksum on load_sum is enabled by defining IMEM_LOAD_CHECKSUM_EN.
module instruction_memory_loadable #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic                  load_done,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  busy,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] load_sum
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun} state_t;

    localparam logic [ADDR_WIDTH:0] LastPtr = (ADDR_WIDTH + 1)'(DEPTH - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   prog_len_q, prog_len_d;
    logic                  load_done_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  data_valid_q;
    logic                  accept;
    logic                  finish;
    logic                  in_range;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        accept     = 1'b0;
        finish     = 1'b0;
        unique case (state_q)
            StIdle, StRun: begin
                if (load_start) begin
                    state_d  = StLoad;
                    wr_ptr_d = '0;
                end
            end
            StLoad: begin
                accept = load_valid;
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    // Filling the last slot ends the load even without load_last.
                    if (load_last || (wr_ptr_q == LastPtr)) begin
                        finish     = 1'b1;
                        prog_len_d = wr_ptr_q + 1'b1;
                        state_d    = StRun;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_range = ({1'b0, address} < prog_len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            load_done_q  <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            prog_len_q  <= prog_len_d;
            load_done_q <= finish;
            if (fetch_en) begin
                // The array is being rewritten during LOAD, so fetches return nothing.
                data_valid_q <= (state_q != StLoad);
                data_q       <= ((state_q != StLoad) && in_range) ? mem[address] : '0;
            end else begin
                data_valid_q <= 1'b0;
            end
        end
    end

    // Array is deliberately not reset; prog_len gates visibility of stale words.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= load_data;
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if ((state_q != StLoad) && (state_d == StLoad)) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + load_data;
        end
    end

    assign load_sum = sum_q;
`else
    assign load_sum = '0;
`endif

    assign load_ready = (state_q == StLoad);
    assign busy       = (state_q == StLoad);
    assign load_done  = load_done_q;
    assign prog_len   = prog_len_q;
    assign data       = data_q;
    assign data_valid = data_valid_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed plus randomized bench for instruction_memory_loadable against an array-based model.
module tb_instruction_memory_loadable;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start, load_valid, load_last, load_ready, load_done, busy;
    logic [7:0] load_data;
    logic [5:0] prog_len;
    logic       fetch_en, data_valid;
    logic [4:0] address;
    logic [7:0] data, load_sum;

    int tests = 0;
    int fails = 0;

    logic [7:0] ref_mem [32];
    int         ref_len;
    logic [7:0] ref_sum;
    logic [7:0] buf_q [$];

    instruction_memory_loadable #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (5),
        .DEPTH      (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done),
        .prog_len   (prog_len),
        .busy       (busy),
        .fetch_en   (fetch_en),
        .address    (address),
        .data       (data),
        .data_valid (data_valid),
        .load_sum   (load_sum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] expect_sum();
`ifdef IMEM_LOAD_CHECKSUM_EN
        return ref_sum;
`else
        return 8'h00;
`endif
    endfunction

    task automatic fetch(input logic [4:0] a);
        logic [7:0] e;
        fetch_en = 1'b1;
        address  = a;
        tick();
        fetch_en = 1'b0;
        e = (int'(a) < ref_len) ? ref_mem[a] : 8'h00;
        chk("fetch_data", 32'(data), 32'(e));
        chk("fetch_valid", 32'(data_valid), 1);
        address = 5'($urandom_range(0, 31));
        tick();
        chk("hold_data", 32'(data), 32'(e));
        chk("idle_valid", 32'(data_valid), 0);
    endtask

    // Streams buf_q; use_last=0 relies on the DEPTH limit to end the load.
    task automatic do_load(input int n, input bit use_last, input bit gaps, input int done_fetch);
        logic [7:0] e;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("busy_in_load", 32'(busy), 1);
        chk("ready_in_load", 32'(load_ready), 1);
        ref_sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                load_valid = 1'b0;
                load_start = 1'b1;   // must be ignored mid-load
                tick();
                load_start = 1'b0;
                chk("gap_no_done", 32'(load_done), 0);
            end
            load_valid = 1'b1;
            load_data  = buf_q[i];
            load_last  = use_last && (i == n - 1);
            tick();
            ref_mem[i] = buf_q[i];
            ref_sum    = ref_sum + buf_q[i];
            if (i != n - 1) begin
                chk("no_early_done", 32'(load_done), 0);
                chk("still_ready", 32'(load_ready), 1);
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        ref_len    = n;
        chk("load_done", 32'(load_done), 1);
        chk("prog_len", 32'(prog_len), 32'(n));
        chk("busy_after", 32'(busy), 0);
        chk("ready_after", 32'(load_ready), 0);
        chk("load_sum", 32'(load_sum), 32'(expect_sum()));
        if (done_fetch >= 0) begin
            fetch_en = 1'b1;
            address  = 5'(done_fetch);
        end
        tick();
        fetch_en = 1'b0;
        chk("done_pulse_once", 32'(load_done), 0);
        chk("sum_held", 32'(load_sum), 32'(expect_sum()));
        if (done_fetch >= 0) begin
            e = (done_fetch < ref_len) ? ref_mem[done_fetch] : 8'h00;
            chk("done_cycle_fetch", 32'(data), 32'(e));
            chk("done_cycle_valid", 32'(data_valid), 1);
        end
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = 8'h00;
        fetch_en   = 1'b0;
        address    = 5'd0;
        ref_len    = 0;
        ref_sum    = 8'h00;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state and IDLE fetch
        chk("rst_ready", 32'(load_ready), 0);
        chk("rst_done", 32'(load_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_sum", 32'(load_sum), 0);
        chk("rst_len", 32'(prog_len), 0);
        fetch(5'd3);

        // 2: four-word program
        buf_q = '{8'h39, 8'h00, 8'h32, 8'h01};
        do_load(4, 1'b1, 1'b0, 3);
        fetch(5'd2);
        chk("t2_addr2", 32'(data), 32'h32);
        fetch(5'd4);
        chk("t2_addr4", 32'(data), 0);

        // 3: load_valid toggling
        buf_q = '{8'hA6, 8'hEF, 8'h80};
        do_load(3, 1'b1, 1'b1, -1);
        for (int a = 0; a < 4; a++) fetch(5'(a));

        // 4: fill to DEPTH without load_last, then a stray beat must be refused
        buf_q.delete();
        for (int i = 0; i < 32; i++) buf_q.push_back(8'(i * 3));
        do_load(32, 1'b0, 1'b0, -1);
        load_valid = 1'b1;
        load_data  = 8'hEE;
        tick();
        load_valid = 1'b0;
        chk("full_ready", 32'(load_ready), 0);
        chk("full_busy", 32'(busy), 0);
        fetch(5'd31);
        chk("t4_addr31", 32'(data), 32'h5D);
        fetch(5'd0);

        // 5: load_start with fetch in RUN, fetch during LOAD, reset mid-load
        fetch_en   = 1'b1;
        address    = 5'd2;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("run_start_fetch", 32'(data), 32'(ref_mem[2]));
        chk("run_start_valid", 32'(data_valid), 1);
        chk("run_start_busy", 32'(busy), 1);
        load_valid = 1'b1;
        load_data  = 8'h11;
        address    = 5'd1;
        tick();
        fetch_en = 1'b0;
        chk("load_fetch_data", 32'(data), 0);
        chk("load_fetch_valid", 32'(data_valid), 0);
        load_data = 8'h22;
        tick();
        load_valid = 1'b0;
        ref_mem[0] = 8'h11;
        ref_mem[1] = 8'h22;
        chk("prog_len_held", 32'(prog_len), 32);
        #2;
        reset = 1'b1;
        #1;
        ref_len = 0;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(load_ready), 0);
        chk("mid_rst_len", 32'(prog_len), 0);
        tick();
        reset = 1'b0;
        fetch(5'd0);
        fetch(5'd1);

        // 6: checksum wraps modulo 256
        buf_q = '{8'hFF, 8'h02, 8'h10};
        do_load(3, 1'b1, 1'b0, 1);

        // Randomized loads and fetches
        for (int r = 0; r < 6; r++) begin
            int n;
            bit ul;
            n  = $urandom_range(1, 32);
            ul = (n < 32) ? 1'b1 : 1'($urandom_range(0, 1));
            buf_q.delete();
            for (int i = 0; i < n; i++) buf_q.push_back(8'($urandom));
            do_load(n, ul, 1'($urandom_range(0, 1)), $urandom_range(0, 31));
            for (int k = 0; k < 8; k++) fetch(5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
